// File: rtl/mem_bit_sequencer_pkg.sv
// Shared definitions for the pattern-RAM bit sequencer: FSM state encoding
// and the read-to-output latency that sets how long the pipeline drains.
package mem_bit_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } seq_state_t;

  // RAM DOA register plus SER_OUT register.
  localparam int RAM_LATENCY = 2;
  localparam int DRAIN_CNT_W = 2;

endpackage

// File: rtl/mem_bit_sequencer.sv
// Plays a bit pattern out of the 1-bit RAM port as a gap-free serial stream,
// walking an address window a programmable number of times.
import mem_bit_sequencer_pkg::*;

module mem_bit_sequencer #(
  parameter int ADDR_WIDTH = 14,
  parameter int REP_WIDTH  = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic                  i_stop,
  input  logic [ADDR_WIDTH-1:0] i_start_addr,
  input  logic [ADDR_WIDTH:0]   i_length,
  input  logic [REP_WIDTH-1:0]  i_repeat,
  output logic                  o_mem_en,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  input  logic                  i_mem_data,
  output logic                  o_ser_out,
  output logic                  o_ser_valid,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam int LEN_W = ADDR_WIDTH + 1;

  seq_state_t             r_state;
  logic [ADDR_WIDTH-1:0]  r_start_addr;
  logic [LEN_W-1:0]       r_length;
  logic [REP_WIDTH-1:0]   r_repeat;
  logic [ADDR_WIDTH-1:0]  r_addr;
  logic [LEN_W-1:0]       r_bit_cnt;
  logic [REP_WIDTH-1:0]   r_pass_cnt;
  logic [DRAIN_CNT_W-1:0] r_drain_cnt;
  logic                   r_mem_en;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_pipe_valid;
  logic                   r_ser_valid;
  logic                   r_ser_out;

  logic w_pass_end;
  logic w_last_issue;

  // r_bit_cnt holds the 1-based index of the bit being issued this cycle.
  assign w_pass_end   = (r_bit_cnt == r_length);
  assign w_last_issue = w_pass_end && (r_repeat != '0) &&
                        (r_pass_cnt == r_repeat - REP_WIDTH'(1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= IDLE;
      r_start_addr <= '0;
      r_length     <= '0;
      r_repeat     <= '0;
      r_addr       <= '0;
      r_bit_cnt    <= '0;
      r_pass_cnt   <= '0;
      r_drain_cnt  <= '0;
      r_mem_en     <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (i_start && !i_stop) begin
            r_start_addr <= i_start_addr;
            r_length     <= i_length;
            r_repeat     <= i_repeat;
            if (i_length == '0) begin
              r_state <= FIN;
              r_done  <= 1'b1;
            end else begin
              r_state    <= RUN;
              r_mem_en   <= 1'b1;
              r_busy     <= 1'b1;
              r_addr     <= i_start_addr;
              r_bit_cnt  <= LEN_W'(1);
              r_pass_cnt <= '0;
            end
          end
        end
        RUN: begin
          if (w_last_issue || i_stop) begin
            r_state     <= DRAIN;
            r_mem_en    <= 1'b0;
            r_drain_cnt <= DRAIN_CNT_W'(RAM_LATENCY - 1);
          end else if (w_pass_end) begin
            r_addr     <= r_start_addr;
            r_bit_cnt  <= LEN_W'(1);
            r_pass_cnt <= r_pass_cnt + REP_WIDTH'(1);
          end else begin
            r_addr    <= r_addr + ADDR_WIDTH'(1);
            r_bit_cnt <= r_bit_cnt + LEN_W'(1);
          end
        end
        DRAIN: begin
          if (r_drain_cnt == '0) begin
            r_state <= FIN;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_drain_cnt <= r_drain_cnt - DRAIN_CNT_W'(1);
          end
        end
        FIN: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Valid tracks the read through the RAM register and into SER_OUT.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pipe_valid <= 1'b0;
      r_ser_valid  <= 1'b0;
      r_ser_out    <= 1'b0;
    end else begin
      r_pipe_valid <= r_mem_en;
      r_ser_valid  <= r_pipe_valid;
      r_ser_out    <= r_pipe_valid & i_mem_data;
    end
  end

  assign o_mem_en    = r_mem_en;
  assign o_mem_addr  = r_addr;
  assign o_ser_out   = r_ser_out;
  assign o_ser_valid = r_ser_valid;
  assign o_busy      = r_busy;
  assign o_done      = r_done;

endmodule

// File: tb/tb_mem_bit_sequencer.sv
// Self-checking bench for mem_bit_sequencer: a behavioural RAM plus a
// stream-level reference model of which bits appear on which cycle.
module tb_mem_bit_sequencer;

  localparam int AW        = 14;
  localparam int LW        = AW + 1;
  localparam int RW        = 8;
  localparam int RAM_DEPTH = 1 << AW;
  localparam int MAXCAP    = 16400;

  logic          clk;
  logic          rstN;
  logic          start;
  logic          stop;
  logic [AW-1:0] startAddr;
  logic [AW:0]   length;
  logic [RW-1:0] repeatN;
  logic          memEn;
  logic [AW-1:0] memAddr;
  logic          memData;
  logic          serOut;
  logic          serValid;
  logic          busy;
  logic          done;

  logic          ram [RAM_DEPTH];
  logic          capEn    [MAXCAP];
  logic [AW-1:0] capAddr  [MAXCAP];
  logic          capValid [MAXCAP];
  logic          capOut   [MAXCAP];
  logic          capBusy  [MAXCAP];
  logic          capDone  [MAXCAP];

  int compared   = 0;
  int mismatched = 0;

  typedef struct packed {
    logic          en;
    logic [AW-1:0] addr;
    logic          valid;
    logic          out;
    logic          busy;
    logic          done;
  } exp_t;

  mem_bit_sequencer #(.ADDR_WIDTH(AW), .REP_WIDTH(RW)) dut (
    .i_clk        (clk),
    .i_rst_n      (rstN),
    .i_start      (start),
    .i_stop       (stop),
    .i_start_addr (startAddr),
    .i_length     (length),
    .i_repeat     (repeatN),
    .o_mem_en     (memEn),
    .o_mem_addr   (memAddr),
    .i_mem_data   (memData),
    .o_ser_out    (serOut),
    .o_ser_valid  (serValid),
    .o_busy       (busy),
    .o_done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (memEn) memData <= ram[memAddr];

  // k counts cycles after the edge that samples START (k=1 is t+1).
  // The run issues n bits back to back; the stream follows two cycles later.
  function automatic exp_t model(input int k, input int sa, input int len,
                                 input int rep, input int stopOff);
    exp_t e;
    int total;
    int n;
    e = '0;
    if (len == 0) begin
      e.done = (k == 1);
      return e;
    end
    total = (rep == 0) ? (1 << 30) : len * rep;
    n = (stopOff > 0 && stopOff < total) ? stopOff : total;
    if (k >= 1 && k <= n) begin
      e.en   = 1'b1;
      e.addr = AW'((sa + (k - 1) % len) % RAM_DEPTH);
    end
    if (k >= 3 && k <= n + 2) begin
      e.valid = 1'b1;
      e.out   = ram[(sa + (k - 3) % len) % RAM_DEPTH];
    end
    e.busy = (k >= 1 && k <= n + 2);
    e.done = (k == n + 3);
    return e;
  endfunction

  // Called at a negedge with the DUT idle; START is sampled at the next edge.
  task automatic applyStimulus(input int sa, input int len, input int rep,
                               input int n, input int stopOff, input int restartOff);
    startAddr = AW'(sa);
    length    = LW'(len);
    repeatN   = RW'(rep);
    start     = 1'b1;
    stop      = 1'b0;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      capEn[k]    = memEn;
      capAddr[k]  = memAddr;
      capValid[k] = serValid;
      capOut[k]   = serOut;
      capBusy[k]  = busy;
      capDone[k]  = done;
      start = (k == restartOff);
      stop  = (k == stopOff);
      if (k == 1) begin
        startAddr = AW'($urandom);
        length    = LW'($urandom_range(1, 40));
        repeatN   = RW'($urandom_range(1, 9));
      end
    end
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic test_reset;
    rstN = 1'b1; start = 1'b0; stop = 1'b0;
    startAddr = '0; length = '0; repeatN = '0;
    #1 rstN = 1'b0;
    #2;
    compared++;
    if ({memEn, memAddr, serValid, serOut, busy, done} !== '0) begin
      mismatched++;
      $display("[TB] FAIL reset outputs got en=%b addr=%h vld=%b out=%b busy=%b done=%b want all 0",
               memEn, memAddr, serValid, serOut, busy, done);
    end
    @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    exp_t e;
    ram[16] = 1'b1; ram[17] = 1'b0; ram[18] = 1'b1; ram[19] = 1'b1; ram[20] = 1'b0;
    applyStimulus(16'h0010, 5, 1, 10, 0, 0);
    for (int k = 1; k <= 10; k++) begin
      e = model(k, 16'h0010, 5, 1, 0);
      compared++;
      if ({capEn[k], capValid[k], capBusy[k], capDone[k]} !== {e.en, e.valid, e.busy, e.done}) begin
        mismatched++;
        $display("[TB] FAIL basic ctl k=%0d got en/vld/busy/done=%b%b%b%b want %b%b%b%b", k,
                 capEn[k], capValid[k], capBusy[k], capDone[k], e.en, e.valid, e.busy, e.done);
      end
      if (e.en) begin
        compared++;
        if (capAddr[k] !== e.addr) begin
          mismatched++;
          $display("[TB] FAIL basic addr k=%0d got %h want %h", k, capAddr[k], e.addr);
        end
      end
    end
    compared++;
    if ({capOut[3], capOut[4], capOut[5], capOut[6], capOut[7]} !== 5'b10110) begin
      mismatched++;
      $display("[TB] FAIL basic stream got %b%b%b%b%b want 10110",
               capOut[3], capOut[4], capOut[5], capOut[6], capOut[7]);
    end
    compared++;
    if (capDone[8] !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL basic done_t8 got %b want 1", capDone[8]);
    end
  endtask

  task automatic test_wrap;
    exp_t e;
    applyStimulus(16'h3FFE, 4, 2, 12, 0, 0);
    for (int k = 1; k <= 12; k++) begin
      e = model(k, 16'h3FFE, 4, 2, 0);
      compared++;
      if ({capEn[k], capValid[k], capBusy[k], capDone[k]} !== {e.en, e.valid, e.busy, e.done}) begin
        mismatched++;
        $display("[TB] FAIL wrap ctl k=%0d got en/vld/busy/done=%b%b%b%b want %b%b%b%b", k,
                 capEn[k], capValid[k], capBusy[k], capDone[k], e.en, e.valid, e.busy, e.done);
      end
      if (e.en) begin
        compared++;
        if (capAddr[k] !== e.addr) begin
          mismatched++;
          $display("[TB] FAIL wrap addr k=%0d got %h want %h", k, capAddr[k], e.addr);
        end
      end
      if (e.valid) begin
        compared++;
        if (capOut[k] !== e.out) begin
          mismatched++;
          $display("[TB] FAIL wrap data k=%0d got %b want %b", k, capOut[k], e.out);
        end
      end
    end
  endtask

  task automatic test_infinite_stop;
    exp_t e;
    int sa;
    sa = $urandom_range(0, RAM_DEPTH - 1);
    applyStimulus(sa, 3, 0, 16, 10, 0);
    for (int k = 1; k <= 16; k++) begin
      e = model(k, sa, 3, 0, 10);
      compared++;
      if ({capEn[k], capValid[k], capBusy[k], capDone[k]} !== {e.en, e.valid, e.busy, e.done}) begin
        mismatched++;
        $display("[TB] FAIL stop ctl k=%0d got en/vld/busy/done=%b%b%b%b want %b%b%b%b", k,
                 capEn[k], capValid[k], capBusy[k], capDone[k], e.en, e.valid, e.busy, e.done);
      end
      if (e.valid) begin
        compared++;
        if (capOut[k] !== e.out) begin
          mismatched++;
          $display("[TB] FAIL stop data k=%0d got %b want %b", k, capOut[k], e.out);
        end
      end
    end
  endtask

  task automatic test_empty_and_ignored_start;
    exp_t e;
    int sa;
    applyStimulus(123, 0, 3, 4, 0, 0);
    for (int k = 1; k <= 4; k++) begin
      e = model(k, 123, 0, 3, 0);
      compared++;
      if ({capEn[k], capValid[k], capBusy[k], capDone[k]} !== {e.en, e.valid, e.busy, e.done}) begin
        mismatched++;
        $display("[TB] FAIL empty ctl k=%0d got en/vld/busy/done=%b%b%b%b want %b%b%b%b", k,
                 capEn[k], capValid[k], capBusy[k], capDone[k], e.en, e.valid, e.busy, e.done);
      end
    end
    sa = $urandom_range(0, RAM_DEPTH - 1);
    applyStimulus(sa, 6, 2, 16, 0, 4);
    for (int k = 1; k <= 16; k++) begin
      e = model(k, sa, 6, 2, 0);
      compared++;
      if ({capEn[k], capValid[k], capBusy[k], capDone[k]} !== {e.en, e.valid, e.busy, e.done}) begin
        mismatched++;
        $display("[TB] FAIL restart ctl k=%0d got en/vld/busy/done=%b%b%b%b want %b%b%b%b", k,
                 capEn[k], capValid[k], capBusy[k], capDone[k], e.en, e.valid, e.busy, e.done);
      end
      if (e.en) begin
        compared++;
        if (capAddr[k] !== e.addr) begin
          mismatched++;
          $display("[TB] FAIL restart addr k=%0d got %h want %h", k, capAddr[k], e.addr);
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    exp_t e;
    int sa [2];
    int len [2];
    int rep [2];
    sa[0] = $urandom_range(0, RAM_DEPTH - 1); len[0] = 3; rep[0] = 2;
    sa[1] = $urandom_range(0, RAM_DEPTH - 1); len[1] = 4; rep[1] = 1;
    for (int r = 0; r < 2; r++) begin
      applyStimulus(sa[r], len[r], rep[r], len[r] * rep[r] + 4, 0, 0);
      for (int k = 1; k <= len[r] * rep[r] + 4; k++) begin
        e = model(k, sa[r], len[r], rep[r], 0);
        compared++;
        if ({capEn[k], capValid[k], capBusy[k], capDone[k]} !== {e.en, e.valid, e.busy, e.done}) begin
          mismatched++;
          $display("[TB] FAIL b2b%0d ctl k=%0d got en/vld/busy/done=%b%b%b%b want %b%b%b%b", r, k,
                   capEn[k], capValid[k], capBusy[k], capDone[k], e.en, e.valid, e.busy, e.done);
        end
        if (e.valid) begin
          compared++;
          if (capOut[k] !== e.out) begin
            mismatched++;
            $display("[TB] FAIL b2b%0d data k=%0d got %b want %b", r, k, capOut[k], e.out);
          end
        end
      end
    end
  endtask

  task automatic test_reset_midrun;
    exp_t e;
    int sa;
    sa = $urandom_range(0, RAM_DEPTH - 1);
    startAddr = AW'(sa); length = LW'(7); repeatN = RW'(3); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rstN = 1'b0;
    #1;
    compared++;
    if ({memEn, memAddr, serValid, serOut, busy, done} !== '0) begin
      mismatched++;
      $display("[TB] FAIL midreset outputs got en=%b addr=%h vld=%b out=%b busy=%b done=%b want all 0",
               memEn, memAddr, serValid, serOut, busy, done);
    end
    @(negedge clk);
    rstN = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      compared++;
      if ({memEn, serValid, busy, done} !== 4'b0000) begin
        mismatched++;
        $display("[TB] FAIL midreset quiet k=%0d got en/vld/busy/done=%b%b%b%b want 0000",
                 k, memEn, serValid, busy, done);
      end
    end
    applyStimulus(sa, 7, 1, 11, 0, 0);
    for (int k = 1; k <= 11; k++) begin
      e = model(k, sa, 7, 1, 0);
      compared++;
      if ({capEn[k], capValid[k], capBusy[k], capDone[k]} !== {e.en, e.valid, e.busy, e.done}) begin
        mismatched++;
        $display("[TB] FAIL replay ctl k=%0d got en/vld/busy/done=%b%b%b%b want %b%b%b%b", k,
                 capEn[k], capValid[k], capBusy[k], capDone[k], e.en, e.valid, e.busy, e.done);
      end
      if (e.valid) begin
        compared++;
        if (capOut[k] !== e.out) begin
          mismatched++;
          $display("[TB] FAIL replay data k=%0d got %b want %b", k, capOut[k], e.out);
        end
      end
    end
  endtask

  task automatic test_random;
    exp_t e;
    int sa, len, rep, stopOff, n;
    for (int it = 0; it < 8; it++) begin
      sa  = $urandom_range(0, RAM_DEPTH - 1);
      len = $urandom_range(1, 12);
      rep = $urandom_range(0, 4);
      if (rep == 0) stopOff = $urandom_range(1, 40);
      else stopOff = ($urandom_range(0, 1) == 1) ? $urandom_range(1, len * rep) : 0;
      n = ((rep == 0) ? stopOff : len * rep) + 5;
      applyStimulus(sa, len, rep, n, stopOff, 0);
      for (int k = 1; k <= n; k++) begin
        e = model(k, sa, len, rep, stopOff);
        compared++;
        if ({capEn[k], capValid[k], capBusy[k], capDone[k]} !== {e.en, e.valid, e.busy, e.done}) begin
          mismatched++;
          $display("[TB] FAIL rand%0d ctl k=%0d got en/vld/busy/done=%b%b%b%b want %b%b%b%b", it, k,
                   capEn[k], capValid[k], capBusy[k], capDone[k], e.en, e.valid, e.busy, e.done);
        end
        if (e.en) begin
          compared++;
          if (capAddr[k] !== e.addr) begin
            mismatched++;
            $display("[TB] FAIL rand%0d addr k=%0d got %h want %h", it, k, capAddr[k], e.addr);
          end
        end
        if (e.valid) begin
          compared++;
          if (capOut[k] !== e.out) begin
            mismatched++;
            $display("[TB] FAIL rand%0d data k=%0d got %b want %b", it, k, capOut[k], e.out);
          end
        end
      end
    end
  endtask

  task automatic test_full;
    exp_t e;
    int sa;
    int validCount;
    int doneCount;
    sa = $urandom_range(0, RAM_DEPTH - 1);
    validCount = 0;
    doneCount = 0;
    applyStimulus(sa, RAM_DEPTH, 1, RAM_DEPTH + 5, 0, 0);
    for (int k = 1; k <= RAM_DEPTH + 5; k++) begin
      e = model(k, sa, RAM_DEPTH, 1, 0);
      if (capValid[k] === 1'b1) validCount++;
      if (capDone[k] === 1'b1) doneCount++;
      if (e.valid) begin
        compared++;
        if (capOut[k] !== e.out) begin
          mismatched++;
          $display("[TB] FAIL full data k=%0d got %b want %b", k, capOut[k], e.out);
        end
      end
    end
    compared++;
    if (validCount != RAM_DEPTH) begin
      mismatched++;
      $display("[TB] FAIL full valid_count got %0d want %0d", validCount, RAM_DEPTH);
    end
    compared++;
    if (doneCount != 1 || capDone[RAM_DEPTH + 3] !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL full done got count=%0d at_end=%b want count=1 at_end=1",
               doneCount, capDone[RAM_DEPTH + 3]);
    end
  endtask

  initial begin
    for (int i = 0; i < RAM_DEPTH; i++) ram[i] = 1'($urandom);
    test_reset();
    test_basic();
    test_wrap();
    test_infinite_stop();
    test_empty_and_ignored_start();
    test_back_to_back();
    test_reset_midrun();
    test_random();
    test_full();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mem_bit_sequencer.md
# mem_bit_sequencer

Read-side sequencer that plays a bit pattern out of the 1-bit-wide port of the 16384 x 1 / 8192 x 2 dual-port pattern RAM as a gap-free serial stream. Software writes the pattern through the 2-bit port. This block owns the 1-bit port, with its write enable tied low at instantiation, and sits between that RAM and the serial output driver. It walks a programmable address window a programmable number of times and reports completion with a one-cycle pulse.

## Interface
- ADDR_WIDTH, 14, RAM 1-bit-port address width
- REP_WIDTH, 8, repeat counter width
- CLK  in  1  single clock, shared with RAM port A
- RST_N  in  1  reset, asynchronous assert, active-low
- START  in  1  start request, level-sampled in IDLE
- STOP  in  1  abort request, sampled in RUN
- START_ADDR  in  ADDR_WIDTH  first bit address
- LENGTH  in  ADDR_WIDTH+1  bits per pass, 1..2^ADDR_WIDTH; 0 = empty run
- REPEAT  in  REP_WIDTH  number of passes; 0 = repeat until STOP
- MEM_EN  out  1  RAM read enable (port A ENA)
- MEM_ADDR  out  ADDR_WIDTH  RAM read address (ADDRA)
- MEM_DATA  in  1  RAM read data (DOA), valid the cycle after MEM_EN
- SER_OUT  out  1  serial data, registered
- SER_VALID  out  1  SER_OUT holds a pattern bit
- BUSY  out  1  run in progress
- DONE  out  1  one-cycle completion pulse

## Operation
- Reset values: all outputs 0; state IDLE; counters 0.
- FSM states: IDLE, RUN, DRAIN, FIN.
- IDLE:
  - START=1 and STOP=0 latches START_ADDR, LENGTH and REPEAT.
  - LENGTH=0 goes to FIN.
  - Otherwise goes to RUN.
  - START and STOP together in IDLE: ignored.
- RUN:
  - MEM_EN=1 every cycle.
  - MEM_ADDR starts at START_ADDR and increments by 1 each cycle, wrapping modulo 2^ADDR_WIDTH.
  - A bit counter counts to LENGTH.
  - At the end of a pass, MEM_ADDR reloads START_ADDR in the next cycle with no idle cycle, and the pass counter increments.
  - The cycle that issues the last bit of pass REPEAT (REPEAT≠0) goes to DRAIN.
- STOP in RUN: the current cycle's read is still issued, then DRAIN.
- DRAIN: MEM_EN=0. Waits until the two in-flight bits (RAM latency plus output register) have left SER_OUT, then goes to FIN.
- FIN: DONE=1 for exactly one cycle, then IDLE.
- START while not in IDLE is ignored. Latched parameters are stable for the whole run.
- Input changes mid-run have no effect.
- Counter widths:
  - bit counter is ADDR_WIDTH+1 bits;
  - pass counter is REP_WIDTH bits;
  - in infinite mode (REPEAT=0) the pass counter is not compared.

## Timing
- START sampled high at edge of cycle t:
  - t+1: MEM_EN=1, MEM_ADDR=START_ADDR, BUSY=1.
  - t+3: first SER_VALID, carrying bit RAM[START_ADDR].
- Latency from MEM_ADDR to SER_OUT is 2 cycles: RAM DOA register plus SER_OUT register.
- SER_VALID stays high for exactly LENGTH×REPEAT consecutive cycles, with no bubbles across pass boundaries.
- DONE comes in the cycle after the last SER_VALID. BUSY covers t+1 through the last SER_VALID cycle; BUSY=0 in the DONE cycle.
- LENGTH=0: DONE at t+1, with BUSY, MEM_EN and SER_VALID never asserted.
- STOP sampled at edge of cycle s in RUN:
  - MEM_EN=0 from s+1.
  - Last SER_VALID at s+2.
  - DONE at s+3.
- RST_N low at any time, including mid-run, clears all outputs and the FSM to IDLE immediately. In-flight data is discarded and no DONE is produced.
- The back-to-back START earliest accepted is in the DONE cycle+1 (IDLE).

## Structure
- Shared include file holds:
  - FSM state encoding localparams (IDLE, RUN, DRAIN, FIN);
  - the RAM latency constant (2, RAM plus output register) used for DRAIN length.
- One module. No sub-module is warranted: the FSM, address/bit counter, pass counter and 2-deep valid shift register are all small.
- RAM instantiated by the parent, not inside this block.

## Test plan
- START_ADDR=0x0010, LENGTH=5, REPEAT=1, RAM[0x10..0x14]=1,0,1,1,0 -> SER_OUT 1,0,1,1,0 on cycles t+3..t+7; DONE at t+8; BUSY t+1..t+7.
- START_ADDR=0x3FFE, LENGTH=4, REPEAT=2 -> MEM_ADDR 3FFE,3FFF,0000,0001,3FFE,... ; 8 contiguous SER_VALID cycles; one DONE.
- REPEAT=0, LENGTH=3, STOP asserted 10 cycles after START -> MEM_EN low next cycle; 2 trailing valid bits; DONE 3 cycles after STOP sample; pattern periodic with period 3.
- LENGTH=0 -> DONE at t+1 only; no MEM_EN, no BUSY; second START during run ignored (bit count unchanged).
- RST_N pulsed low mid-RUN -> all outputs 0 same cycle, no DONE; a fresh START afterwards replays from START_ADDR correctly.
- LENGTH=16384, REPEAT=1 -> 16384 valid bits; full RAM read once; DONE once.
